univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register: a WIDTH-bit register that accepts one command per handshake. Commands are parallel load, bitwise invert, and multi-bit shift or rotate with a serial fill bit. Multi-bit operations run one bit position per clock under a small FSM, with busy/done status. It is the general-purpose successor to the team's fixed 4-bit mode-select register and is used wherever datapath code needs a shift or rotate of arbitrary width and distance.

## Interface
- WIDTH, default 8: register width in bits, must be at least 2.
- AW, default $clog2(WIDTH)+1: width of the shift-amount port. Derived; do not override.
- clk, input, 1: the single clock. All state changes on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- load, input, 1: command strobe. Sampled only in IDLE.
- i, input, WIDTH: parallel load data.
- j, input, 3: opcode.
  - 000 LOAD
  - 001 INV
  - 010 SHR (fill MSB with sin)
  - 011 SHL (fill LSB with sin)
  - 100 ROR
  - 101 ROL
  - 110 ASR
  - 111 NOP
- amt, input, AW: shift or rotate distance. Values above WIDTH saturate to WIDTH.
- sin, input, 1: serial fill bit for SHR and SHL. Sampled on every shift edge.
- o, output, WIDTH: register contents.
- sout, output, 1: bit shifted or rotated out on the most recent shift edge.
- busy, output, 1: high while a multi-cycle command is executing.
- done, output, 1: one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE and SHIFT.
- IDLE with load=1 accepts the command on that edge.
- Single-edge commands:
  - LOAD sets o=i.
  - INV sets o=~o.
  - NOP leaves o unchanged.
  - Any shift or rotate with amt=0 leaves o unchanged.
  - All four stay in IDLE and pulse done.
- Shift and rotate with amt=n≥1:
  - The accepting edge latches the opcode and count n (saturated), enters SHIFT, and leaves o unchanged.
  - Each following edge performs one single-bit step and decrements the count.
  - The step that takes the count to zero returns the FSM to IDLE and pulses done.
- Single-bit steps:
  - SHR: o={sin,o[W-1:1]}, sout=o[0].
  - SHL: o={o[W-2:0],sin}, sout=o[W-1].
  - ROR and ROL: circular; sout is the bit that wrapped.
  - ASR: o={o[W-1],o[W-1:1]}, sout=o[0].
- load in SHIFT is ignored. It is not queued.
- Opcode and count are latched at acceptance, so changes to i, j or amt during SHIFT have no effect. sin is live.
- Rotate by WIDTH returns the original value.
- Shift by WIDTH fills the whole register with sin (SHR/SHL) or the sign bit (ASR).

## Timing
- Reset values: o=0, sout=0, busy=0, done=0, FSM=IDLE.
- reset dominates every other input, including mid-SHIFT: the next edge forces the reset values.
- Single-edge command accepted at edge k: o is valid after edge k, done is high for the cycle following edge k, busy stays 0.
- Shift accepted at edge k with count n:
  - busy is high from edge k to edge k+n.
  - Steps occur at edges k+1 through k+n.
  - done is high for the single cycle after edge k+n.
  - Total latency is n+1 edges.
- A new command may be accepted in the same cycle that done is high.
- done and busy are never high together.

## Configuration
- UNIV_SHIFT_REG_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 in SHIFT returns the FSM to IDLE on that edge with no step performed.
  - o keeps its partial result; done is not pulsed.
  - abort in IDLE has no effect.
- UNIV_SHIFT_REG_ABORT_EN not defined: no abort port; commands always run to completion.

## Structure
- Package univ_shift_reg_pkg holds:
  - the opcode enum (values listed above),
  - the FSM state enum,
  - the saturation helper function.
- Sub-module univ_shift_step: combinational single-bit step.
  - Inputs: o, opcode, sin.
  - Outputs: next value, out bit.
  - The top-level holds the register, the count and the FSM.

## Test plan
Scenarios 1–5 use WIDTH=8; scenario 6 uses WIDTH=5.
1. Reset asserted during a shift -> next edge o=0x00, busy=0, done=0, sout=0; subsequent load is accepted normally.
2. LOAD i=0xA5 -> o=0xA5 after 1 edge, done for 1 cycle; then INV -> o=0x5A, busy never high.
3. o=0x81, ROL amt=3 -> busy for 3 cycles, o goes 0x03, 0x06, 0x0C, sout goes 1, 0, 0, then done.
4. o=0x80, ASR amt=2 -> o=0xE0. From o=0x00, SHR amt=15 with sin=1 -> saturates to 8 steps, o=0xFF, busy for 8 cycles.
5. LOAD i=0x11 asserted during a ROR amt=4 of 0x0F -> ignored, final o=0xF0. A back-to-back command in the done cycle is accepted.
6. With UNIV_SHIFT_REG_ABORT_EN: SHL amt=4 of 0x01, abort after 2 steps -> o=0x04, no done pulse, FSM=IDLE. Without the macro, rotate by 5 of 0x15 -> o=0x15.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// ============================================================================
// Module      : univ_shift_reg_pkg
// Description : Opcodes, FSM encoding and amount saturation for univ_shift_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package univ_shift_reg_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_INV  = 3'b001,
        OP_SHR  = 3'b010,
        OP_SHL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ASR  = 3'b110,
        OP_NOP  = 3'b111
    } opcode_t;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // Distances beyond the register width are clamped to the width.
    function automatic int unsigned sat_amt(input int unsigned amt, input int unsigned width);
        return (amt > width) ? width : amt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/univ_shift_step.sv
// ============================================================================
// Module      : univ_shift_step
// Description : Combinational single-bit shift/rotate step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_step
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] o,
    input  opcode_t          opcode,
    input  logic             sin,
    output logic [WIDTH-1:0] nxt,
    output logic             sout
);

    always_comb begin
        nxt  = o;
        sout = 1'b0;
        case (opcode)
            OP_SHR: begin
                nxt  = {sin, o[WIDTH-1:1]};
                sout = o[0];
            end
            OP_SHL: begin
                nxt  = {o[WIDTH-2:0], sin};
                sout = o[WIDTH-1];
            end
            OP_ROR: begin
                nxt  = {o[0], o[WIDTH-1:1]};
                sout = o[0];
            end
            OP_ROL: begin
                nxt  = {o[WIDTH-2:0], o[WIDTH-1]};
                sout = o[WIDTH-1];
            end
            OP_ASR: begin
                nxt  = {o[WIDTH-1], o[WIDTH-1:1]};
                sout = o[0];
            end
            default: begin
                nxt  = o;
                sout = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module      : univ_shift_reg
// Description : Universal shift register; load/invert in one edge, multi-bit
//               shift/rotate one position per clock. Optional abort input
//               enabled by defining UNIV_SHIFT_REG_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] i,
    input  logic [2:0]       j,
    input  logic [AW-1:0]    amt,
    input  logic             sin,
`ifdef UNIV_SHIFT_REG_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] o,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    opcode_t          r_op;
    logic [AW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_o;
    logic             r_sout;
    logic             r_done;

    opcode_t          w_cmd;
    logic [AW-1:0]    w_cnt_init;
    logic [WIDTH-1:0] w_step_nxt;
    logic             w_step_out;
    logic             w_abort;

    assign w_cmd      = opcode_t'(j);
    assign w_cnt_init = AW'(sat_amt(32'(amt), WIDTH));

`ifdef UNIV_SHIFT_REG_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    univ_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .o      (r_o),
        .opcode (r_op),
        .sin    (sin),
        .nxt    (w_step_nxt),
        .sout   (w_step_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_cnt   <= '0;
            r_o     <= '0;
            r_sout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        case (w_cmd)
                            OP_LOAD: begin
                                r_o    <= i;
                                r_done <= 1'b1;
                            end
                            OP_INV: begin
                                r_o    <= ~r_o;
                                r_done <= 1'b1;
                            end
                            OP_NOP: r_done <= 1'b1;
                            default: begin
                                // Zero-distance shifts complete immediately, like NOP.
                                if (w_cnt_init == '0) begin
                                    r_done <= 1'b1;
                                end else begin
                                    r_op    <= w_cmd;
                                    r_cnt   <= w_cnt_init;
                                    r_state <= ST_SHIFT;
                                end
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_o    <= w_step_nxt;
                        r_sout <= w_step_out;
                        r_cnt  <= r_cnt - AW'(1);
                        if (r_cnt == AW'(1)) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o    = r_o;
    assign sout = r_sout;
    assign busy = (r_state == ST_SHIFT);
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// Module      : tb_univ_shift_reg
// Description : Directed self-checking bench for univ_shift_reg (WIDTH 8 and 5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

    localparam logic [2:0] c_load = 3'b000;
    localparam logic [2:0] c_inv  = 3'b001;
    localparam logic [2:0] c_shr  = 3'b010;
    localparam logic [2:0] c_shl  = 3'b011;
    localparam logic [2:0] c_ror  = 3'b100;
    localparam logic [2:0] c_rol  = 3'b101;
    localparam logic [2:0] c_asr  = 3'b110;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sin = 1'b0;
    logic       abort = 1'b0;

    logic       load8 = 1'b0;
    logic [7:0] i8 = '0;
    logic [2:0] j8 = '0;
    logic [3:0] amt8 = '0;
    logic [7:0] o8;
    logic       sout8, busy8, done8;

    logic       load5 = 1'b0;
    logic [4:0] i5 = '0;
    logic [2:0] j5 = '0;
    logic [3:0] amt5 = '0;
    logic [4:0] o5;
    logic       sout5, busy5, done5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .load  (load8),
        .i     (i8),
        .j     (j8),
        .amt   (amt8),
        .sin   (sin),
`ifdef UNIV_SHIFT_REG_ABORT_EN
        .abort (abort),
`endif
        .o     (o8),
        .sout  (sout8),
        .busy  (busy8),
        .done  (done8)
    );

    univ_shift_reg #(.WIDTH(5)) u_dut5 (
        .clk   (clk),
        .reset (reset),
        .load  (load5),
        .i     (i5),
        .j     (j5),
        .amt   (amt5),
        .sin   (sin),
`ifdef UNIV_SHIFT_REG_ABORT_EN
        .abort (abort),
`endif
        .o     (o5),
        .sout  (sout5),
        .busy  (busy5),
        .done  (done5)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd8(input logic [2:0] op, input logic [7:0] data, input logic [3:0] a);
        load8 = 1'b1;
        j8    = op;
        i8    = data;
        amt8  = a;
        tick();
        load8 = 1'b0;
    endtask

    task automatic cmd5(input logic [2:0] op, input logic [4:0] data, input logic [3:0] a);
        load5 = 1'b1;
        j5    = op;
        i5    = data;
        amt5  = a;
        tick();
        load5 = 1'b0;
    endtask

    initial begin
        int cyc;
        abort = 1'b0;
        tick();
        tick();
        check("rst_o", 32'(o8), 32'h00);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sout", 32'(sout8), 32'd0);
        reset = 1'b0;

        // Reset in the middle of a shift
        cmd8(c_load, 8'h3C, 4'd0);
        cmd8(c_shr, 8'h00, 4'd5);
        tick();
        tick();
        check("mid_busy", 32'(busy8), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_o", 32'(o8), 32'h00);
        check("mrst_busy", 32'(busy8), 32'd0);
        check("mrst_done", 32'(done8), 32'd0);
        check("mrst_sout", 32'(sout8), 32'd0);

        // LOAD then INV
        cmd8(c_load, 8'hA5, 4'd0);
        check("load_o", 32'(o8), 32'hA5);
        check("load_done", 32'(done8), 32'd1);
        check("load_busy", 32'(busy8), 32'd0);
        tick();
        check("load_done_clr", 32'(done8), 32'd0);
        cmd8(c_inv, 8'h00, 4'd0);
        check("inv_o", 32'(o8), 32'h5A);
        check("inv_done", 32'(done8), 32'd1);
        check("inv_busy", 32'(busy8), 32'd0);

        // Zero-distance shift is a single-edge no-op
        cmd8(c_shl, 8'h00, 4'd0);
        check("amt0_o", 32'(o8), 32'h5A);
        check("amt0_done", 32'(done8), 32'd1);
        check("amt0_busy", 32'(busy8), 32'd0);

        // ROL 3 of 0x81
        cmd8(c_load, 8'h81, 4'd0);
        cmd8(c_rol, 8'h00, 4'd3);
        check("rol_acc_o", 32'(o8), 32'h81);
        check("rol_acc_busy", 32'(busy8), 32'd1);
        check("rol_acc_done", 32'(done8), 32'd0);
        tick();
        check("rol1_o", 32'(o8), 32'h03);
        check("rol1_sout", 32'(sout8), 32'd1);
        tick();
        check("rol2_o", 32'(o8), 32'h06);
        check("rol2_sout", 32'(sout8), 32'd0);
        check("rol2_busy", 32'(busy8), 32'd1);
        tick();
        check("rol3_o", 32'(o8), 32'h0C);
        check("rol3_sout", 32'(sout8), 32'd0);
        check("rol3_busy", 32'(busy8), 32'd0);
        check("rol3_done", 32'(done8), 32'd1);

        // ASR 2 of 0x80
        cmd8(c_load, 8'h80, 4'd0);
        cmd8(c_asr, 8'h00, 4'd2);
        tick();
        tick();
        check("asr_o", 32'(o8), 32'hE0);
        check("asr_done", 32'(done8), 32'd1);

        // SHR 15 saturates to 8 steps
        cmd8(c_load, 8'h00, 4'd0);
        sin = 1'b1;
        cmd8(c_shr, 8'h00, 4'd15);
        cyc = 0;
        while (busy8 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("shr_sat_cycles", 32'(cyc), 32'd8);
        check("shr_sat_o", 32'(o8), 32'hFF);
        check("shr_sat_done", 32'(done8), 32'd1);
        sin = 1'b0;

        // SHL by full width with sin=0 clears the register
        cmd8(c_shl, 8'h00, 4'd8);
        repeat (8) tick();
        check("shl_full_o", 32'(o8), 32'h00);
        check("shl_full_sout", 32'(sout8), 32'd1);

        // LOAD during ROR is ignored
        cmd8(c_load, 8'h0F, 4'd0);
        cmd8(c_ror, 8'h00, 4'd4);
        load8 = 1'b1;
        j8    = c_load;
        i8    = 8'h11;
        amt8  = 4'd1;
        tick();
        tick();
        load8 = 1'b0;
        check("ror_ign_busy", 32'(busy8), 32'd1);
        tick();
        tick();
        check("ror_o", 32'(o8), 32'hF0);
        check("ror_sout", 32'(sout8), 32'd1);
        check("ror_done", 32'(done8), 32'd1);
        cmd8(c_load, 8'h33, 4'd0);
        check("b2b_o", 32'(o8), 32'h33);
        check("b2b_done", 32'(done8), 32'd1);

        // WIDTH=5: rotate by full width returns the original value
        cmd5(c_load, 5'h15, 4'd0);
        check("w5_load_o", 32'(o5), 32'h15);
        cmd5(c_rol, 5'h00, 4'd5);
        repeat (4) tick();
        check("w5_rol_busy", 32'(busy5), 32'd1);
        tick();
        check("w5_rol_o", 32'(o5), 32'h15);
        check("w5_rol_done", 32'(done5), 32'd1);

`ifdef UNIV_SHIFT_REG_ABORT_EN
        cmd5(c_load, 5'h01, 4'd0);
        cmd5(c_shl, 5'h00, 4'd4);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_o", 32'(o5), 32'h04);
        check("abort_busy", 32'(busy5), 32'd0);
        check("abort_done", 32'(done5), 32'd0);
        tick();
        check("abort_done2", 32'(done5), 32'd0);
        check("abort_o2", 32'(o5), 32'h04);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
